// File: rtl/core101_ctrl_pkg.sv
// rtl/core101_ctrl_pkg.sv - Core101 sequencer stage codes, PC source codes and helpers
package core101_ctrl_pkg;

    // Gray-ordered so the normal IF->ID->EX->MEM->WB walk flips one state bit per step
    localparam logic [2:0] STAGE_IF  = 3'b000;
    localparam logic [2:0] STAGE_ID  = 3'b001;
    localparam logic [2:0] STAGE_EX  = 3'b011;
    localparam logic [2:0] STAGE_MEM = 3'b010;
    localparam logic [2:0] STAGE_WB  = 3'b110;

    typedef enum logic [2:0] {
        ST_IF  = STAGE_IF,
        ST_ID  = STAGE_ID,
        ST_EX  = STAGE_EX,
        ST_MEM = STAGE_MEM,
        ST_WB  = STAGE_WB
    } stage_e;

    localparam logic [1:0] PC_SRC_SEQ      = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH   = 2'b01;
    localparam logic [1:0] PC_SRC_REDIRECT = 2'b10;

    function automatic logic [4:0] stage_onehot(input stage_e s);
        case (s)
            ST_IF:   return 5'b00001;
            ST_ID:   return 5'b00010;
            ST_EX:   return 5'b00100;
            ST_MEM:  return 5'b01000;
            ST_WB:   return 5'b10000;
            default: return 5'b00001;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// rtl/pipeline_sequencer_if.sv - datapath-facing handshake and strobe bundle of the sequencer
interface pipeline_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             stall_in;
    logic             flush_in;
    logic             instr_ready_in;
    logic             mem_ready_in;
    logic             is_mem_op_in;
    logic             branch_taken_in;
    logic             writes_rd_in;
    logic [4:0]       stage_onehot_out;
    logic             pc_set_val_out;
    logic [1:0]       pc_src_out;
    logic             ir_set_val_out;
    logic             if_req_out;
    logic             mem_req_out;
    logic             rf_write_en_out;
    logic             timeout_out;
    logic [CNT_W-1:0] retired_count_out;

    modport master (
        input  stall_in, flush_in, instr_ready_in, mem_ready_in,
               is_mem_op_in, branch_taken_in, writes_rd_in,
        output stage_onehot_out, pc_set_val_out, pc_src_out, ir_set_val_out,
               if_req_out, mem_req_out, rf_write_en_out, timeout_out,
               retired_count_out
    );

    modport slave (
        output stall_in, flush_in, instr_ready_in, mem_ready_in,
               is_mem_op_in, branch_taken_in, writes_rd_in,
        input  stage_onehot_out, pc_set_val_out, pc_src_out, ir_set_val_out,
               if_req_out, mem_req_out, rf_write_en_out, timeout_out,
               retired_count_out
    );
endinterface

// File: rtl/ctrl_wait_timer.sv
// rtl/ctrl_wait_timer.sv - counts stalled-handshake cycles and flags the WAIT_LIMIT-th one
module ctrl_wait_timer #(
    parameter int WAIT_LIMIT = 15,
    parameter int WAIT_W     = 4
) (
    input  logic datapath_clock_in,
    input  logic datapath_reset_in,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [WAIT_W-1:0] count;

    // Fires during the cycle that would be the WAIT_LIMIT-th consecutive wait
    assign expired = enable && (count == WAIT_W'(WAIT_LIMIT - 1));

    always_ff @(negedge datapath_clock_in or posedge datapath_reset_in) begin
        if (datapath_reset_in) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WAIT_W'(1);
        end
    end
endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - multi-cycle IF/ID/EX/MEM/WB control FSM for the Core101 datapath
module pipeline_sequencer
    import core101_ctrl_pkg::*;
#(
    parameter int MEM_SKIP   = 1,
    parameter int WAIT_LIMIT = 15,
    parameter int WAIT_W     = 4,
    parameter int CNT_W      = 32
) (
    input  logic datapath_clock_in,
    input  logic datapath_reset_in,
    pipeline_sequencer_if.master bus
);
    stage_e stage;
    stage_e next_stage;
    logic   mem_op;
    logic   next_mem_op;
    logic   waiting;
    logic   expired;
    logic   abort;

    assign waiting = ((stage == ST_IF) && !bus.instr_ready_in) ||
                     ((stage == ST_MEM) && mem_op && !bus.mem_ready_in);
    assign abort   = bus.flush_in || expired;

    ctrl_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .WAIT_W     (WAIT_W)
    ) u_wait_timer (
        .datapath_clock_in (datapath_clock_in),
        .datapath_reset_in (datapath_reset_in),
        .clear             (abort || (next_stage != stage)),
        .enable            (waiting && !bus.stall_in),
        .expired           (expired)
    );

    always_comb begin
        next_stage  = stage;
        next_mem_op = mem_op;
        if (abort) begin
            next_stage  = ST_IF;
            next_mem_op = 1'b0;
        end else if (!bus.stall_in) begin
            case (stage)
                ST_IF:  if (bus.instr_ready_in) next_stage = ST_ID;
                ST_ID:  next_stage = ST_EX;
                ST_EX: begin
                    next_mem_op = bus.is_mem_op_in;
                    next_stage  = (bus.is_mem_op_in || (MEM_SKIP == 0)) ? ST_MEM : ST_WB;
                end
                // A non-memory op only lands here when MEM_SKIP=0 and passes straight through
                ST_MEM: if (!mem_op || bus.mem_ready_in) next_stage = ST_WB;
                ST_WB:  next_stage = ST_IF;
                default: next_stage = ST_IF;
            endcase
        end
    end

    always_ff @(negedge datapath_clock_in or posedge datapath_reset_in) begin
        if (datapath_reset_in) begin
            stage                 <= ST_IF;
            mem_op                <= 1'b0;
            bus.stage_onehot_out  <= 5'b00001;
            bus.if_req_out        <= 1'b1;
            bus.mem_req_out       <= 1'b0;
            bus.ir_set_val_out    <= 1'b0;
            bus.pc_set_val_out    <= 1'b0;
            bus.pc_src_out        <= PC_SRC_SEQ;
            bus.rf_write_en_out   <= 1'b0;
            bus.timeout_out       <= 1'b0;
            bus.retired_count_out <= '0;
        end else begin
            stage                <= next_stage;
            mem_op               <= next_mem_op;
            bus.stage_onehot_out <= stage_onehot(next_stage);
            bus.if_req_out       <= (next_stage == ST_IF);
            bus.mem_req_out      <= (next_stage == ST_MEM) && next_mem_op;
            bus.ir_set_val_out   <= 1'b0;
            bus.pc_set_val_out   <= 1'b0;
            bus.rf_write_en_out  <= 1'b0;
            if (abort) begin
                bus.pc_set_val_out <= 1'b1;
                bus.pc_src_out     <= PC_SRC_REDIRECT;
                if (expired) bus.timeout_out <= 1'b1;
            end else if (!bus.stall_in) begin
                case (stage)
                    ST_IF: if (bus.instr_ready_in) bus.ir_set_val_out <= 1'b1;
                    ST_EX: bus.pc_src_out <= bus.branch_taken_in ? PC_SRC_BRANCH : PC_SRC_SEQ;
                    ST_WB: begin
                        bus.pc_set_val_out    <= 1'b1;
                        bus.rf_write_en_out   <= bus.writes_rd_in;
                        bus.retired_count_out <= bus.retired_count_out + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
